bcd_conv_arbiter: RTL
=====================

Name: bcd_conv_arbiter

Overview:
- Round-robin scheduler that shares one BCD conversion engine between N_REQ requesters, e.g. frequency, duty-cycle and amplitude display paths in the square generator.
- Each requester presents a binary value with a level request and receives a one-cycle ack with the BCD result.
- The block sequences the engine through a start/done handshake, guards against a hung engine with a timeout, and sits between the control/display logic and the converter.

Parameters:
N_REQ, 3, number of requesters (2..8)
BINARY_LENGTH, 32, width of each binary operand
DECIMAL_LENGTH, 10, number of BCD digits in a result
TIMEOUT_CYCLES, 256, maximum cycles in WAIT before abort (must be > BINARY_LENGTH+4)

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  synchronous reset, active-high
req  in  N_REQ  per-requester conversion request (level)
req_data  in  N_REQ*BINARY_LENGTH  operands; requester k in slice [k*BINARY_LENGTH +: BINARY_LENGTH]
ack  out  N_REQ  one-hot, one-cycle pulse: result for requester k valid
bcd_out  out  DECIMAL_LENGTH*4  result digits, digit 0 in [3:0]; valid during ack and held until the next DELIVER
err  out  1  high with ack when the conversion timed out; bcd_out is then all zeros
busy  out  1  high in every state except IDLE
conv_start  out  1  one-cycle start pulse to the engine
conv_binary  out  BINARY_LENGTH  operand to the engine; stable from START until the next grant
conv_done  in  1  engine completion pulse
conv_bcd  in  DECIMAL_LENGTH*4  engine result; valid in the conv_done cycle

Behaviour:
- Reset (CLK edge with RST=1): state=IDLE; ack=0, err=0, busy=0, conv_start=0, conv_binary=0, bcd_out=0; priority pointer=0, so requester 0 has highest priority; timeout counter=0. RST mid-operation aborts with no ack; a later conv_done is ignored.
- FSM has four states.
- IDLE:
  - If req != 0, grant the first set bit scanning k = ptr, ptr+1, ... modulo N_REQ.
  - Register grant index, latch conv_binary = req_data slice of the grant, go to START.
  - Otherwise stay in IDLE.
- START: conv_start=1 for exactly this cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - On conv_done=1, latch bcd_out=conv_bcd, err=0, go to DELIVER.
  - Otherwise increment the counter. When counter==TIMEOUT_CYCLES-1 with no done, set bcd_out=0, err=1, go to DELIVER.
- DELIVER:
  - ack[grant]=1 and err as latched, both for this cycle only.
  - ptr = (grant+1) mod N_REQ, go to IDLE.
- Latency: req rising in IDLE -> conv_start 2 cycles later (IDLE sample, START); ack exactly 1 cycle after the conv_done cycle.
- Requester contract: hold req and req_data stable until ack; drop req the cycle after ack.
  - A req still high on the cycle after ack is a new request, arbitrated with fairness via the pointer.
- Withdrawal: req dropped after grant does not cancel. The conversion completes and ack still pulses; the requester may ignore it.
- conv_done outside WAIT is ignored. conv_done in the same cycle as the timeout terminal count wins: result delivered, err=0.
- Only one conversion is ever outstanding; there is no queueing beyond the req levels.
- The same BCD width rules as the engine apply: BINARY_LENGTH operand, DECIMAL_LENGTH*4 result. Overflowing digits are the engine's concern and are passed through unmodified.

Decomposition:
- Shared package bcd_pkg:
  - state encoding constants IDLE=0, START=1, WAIT=2, DELIVER=3
  - a clog2-style function for grant/pointer widths
  - the default BINARY_LENGTH and DECIMAL_LENGTH
- One sub-module is natural: rr_priority_picker. It is combinational: inputs req and ptr, outputs a one-hot grant and a valid bit. It is reusable by other shared-resource schedulers.
- The FSM, timeout counter and registers stay in bcd_conv_arbiter.

Test Plan (N_REQ=3, BINARY_LENGTH=8, DECIMAL_LENGTH=3, engine model done 10 cycles after start):
1. Single request: req=3'b001, data0=8'd255 -> conv_start 2 cycles after req, conv_binary=8'hFF, ack=3'b001 one cycle after done, bcd_out=12'h255, err=0.
2. Contention fairness: req=3'b111 held high, data 8'd9/8'd42/8'd100 -> acks in order 001, 010, 100, 001 with bcd_out 12'h009, 12'h042, 12'h100, 12'h009.
3. Pointer skip: after ack to requester 0, req=3'b101 -> requester 2 granted before requester 0.
4. Timeout: engine never asserts done, req=3'b010 -> ack=3'b010 with err=1 and bcd_out=0, TIMEOUT_CYCLES cycles after conv_start. Next request is served normally with err=0.
5. Reset mid-WAIT: assert RST 4 cycles after conv_start -> next cycle all outputs 0, busy=0, no ack. A late conv_done is ignored. Requester 0 is then highest priority.
6. Stray/simultaneous events: conv_done pulsed in IDLE -> no ack. conv_done on the timeout terminal cycle -> ack with err=0 and engine data.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD conversion arbiter: FSM encoding, default
// operand/result widths and an index-width helper.
package bcd_pkg;

  localparam int unsigned BINARY_LENGTH_DEF  = 32;
  localparam int unsigned DECIMAL_LENGTH_DEF = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } state_t;

  // Ceiling log2, clamped to at least 1 bit so 1- and 2-entry indices stay legal.
  function automatic int unsigned clog2w(input int unsigned v);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: one-hot grant of the first set request
// at or after the priority pointer, wrapping modulo N.
module rr_priority_picker #(
  parameter int unsigned N  = 3,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic          valid_o
);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = PW'((32'(ptr_i) + i) % N);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
    valid_o = |req_i;
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin scheduler sharing one BCD conversion engine between N_REQ
// requesters, with start/done handshake and a hung-engine timeout.
module bcd_conv_arbiter
  import bcd_pkg::*;
#(
  parameter int unsigned N_REQ          = 3,
  parameter int unsigned BINARY_LENGTH  = BINARY_LENGTH_DEF,
  parameter int unsigned DECIMAL_LENGTH = DECIMAL_LENGTH_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ*BINARY_LENGTH-1:0] req_data,
  output logic [N_REQ-1:0]              ack,
  output logic [DECIMAL_LENGTH*4-1:0]   bcd_out,
  output logic                          err,
  output logic                          busy,
  output logic                          conv_start,
  output logic [BINARY_LENGTH-1:0]      conv_binary,
  input  logic                          conv_done,
  input  logic [DECIMAL_LENGTH*4-1:0]   conv_bcd
);

  localparam int unsigned PW = clog2w(N_REQ);
  localparam int unsigned CW = clog2w(TIMEOUT_CYCLES);

  state_t                        state_q;
  logic [PW-1:0]                 grant_q;
  logic [PW-1:0]                 ptr_q;
  logic [CW-1:0]                 cnt_q;
  logic [N_REQ-1:0]              ack_q;
  logic                          err_q;
  logic                          busy_q;
  logic                          start_q;
  logic [BINARY_LENGTH-1:0]      bin_q;
  logic [DECIMAL_LENGTH*4-1:0]   bcd_q;

  logic [N_REQ-1:0]              grant_oh;
  logic                          pick_valid;
  logic [PW-1:0]                 grant_idx;
  logic [BINARY_LENGTH-1:0]      pick_data;

  rr_priority_picker #(
    .N  (N_REQ),
    .PW (PW)
  ) u_picker (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (grant_oh),
    .valid_o (pick_valid)
  );

  always_comb begin
    grant_idx = '0;
    pick_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_oh[i]) begin
        grant_idx = PW'(i);
        pick_data = req_data[i*BINARY_LENGTH +: BINARY_LENGTH];
      end
    end
  end

  // Outputs are registered on the transition out of each state, so conv_start
  // is seen in the first WAIT cycle and ack/err coincide with DELIVER.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      bin_q   <= '0;
      bcd_q   <= '0;
    end else begin
      start_q <= 1'b0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_q <= grant_idx;
            bin_q   <= pick_data;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          cnt_q   <= '0;
          start_q <= 1'b1;
          state_q <= WAIT;
        end
        WAIT: begin
          if (conv_done) begin
            bcd_q   <= conv_bcd;
            ack_q   <= N_REQ'(1) << grant_q;
            state_q <= DELIVER;
          end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            bcd_q   <= '0;
            ack_q   <= N_REQ'(1) << grant_q;
            err_q   <= 1'b1;
            state_q <= DELIVER;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DELIVER: begin
          ptr_q   <= (grant_q == PW'(N_REQ - 1)) ? '0 : grant_q + PW'(1);
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack         = ack_q;
  assign err         = err_q;
  assign busy        = busy_q;
  assign conv_start  = start_q;
  assign conv_binary = bin_q;
  assign bcd_out     = bcd_q;

endmodule
